// File: rtl/cf_elastic_fifo.sv
// Elastic Send/Ack FIFO: circular buffer of DEPTH tokens with registered occupancy and cp pulse.
// Optional saturating stall counter enabled by defining CF_STAT_EN.
module cf_elastic_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4
`ifdef CF_STAT_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic                       CLK,
    input  logic                       MR,
    input  logic                       Send_in,
    input  logic [WIDTH-1:0]           Data_in,
    output logic                       Ack_out,
    output logic                       Send_out,
    output logic [WIDTH-1:0]           Data_out,
    input  logic                       Ack_in,
    output logic                       cp,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef CF_STAT_EN
    ,
    output logic [STAT_W-1:0]          stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             cp_q;
    logic             push, pop;

    // Handshakes are decoded only from registered state, never from the opposite side.
    assign Ack_out  = ~MR & (count_q != CW'(DEPTH));
    assign Send_out = (count_q != '0);
    assign Data_out = Send_out ? mem[rd_ptr_q] : '0;
    assign push     = Send_in & Ack_out;
    assign pop      = Send_out & Ack_in & ~MR;
    assign cp       = cp_q;
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cp_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            cp_q    <= push;
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= Data_in;
    end

`ifdef CF_STAT_EN
    logic [STAT_W-1:0] stall_q;

    always_ff @(posedge CLK) begin
        if (MR) begin
            stall_q <= '0;
        end else if (Send_out && !Ack_in && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cf_elastic_fifo.sv
// Directed self-checking bench for cf_elastic_fifo (WIDTH=8, DEPTH=4).
module tb_cf_elastic_fifo;

    logic       CLK;
    logic       MR;
    logic       Send_in;
    logic [7:0] Data_in;
    logic       Ack_out;
    logic       Send_out;
    logic [7:0] Data_out;
    logic       Ack_in;
    logic       cp;
    logic [2:0] count;
`ifdef CF_STAT_EN
    logic [3:0] stall_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    cf_elastic_fifo #(
        .WIDTH (8),
        .DEPTH (4)
`ifdef CF_STAT_EN
        ,
        .STAT_W(4)
`endif
    ) dut (
        .CLK      (CLK),
        .MR       (MR),
        .Send_in  (Send_in),
        .Data_in  (Data_in),
        .Ack_out  (Ack_out),
        .Send_out (Send_out),
        .Data_out (Data_out),
        .Ack_in   (Ack_in),
        .cp       (cp),
        .count    (count)
`ifdef CF_STAT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        MR = 1'b1; Send_in = 1'b0; Data_in = 8'h00; Ack_in = 1'b0;

        // 1: reset held two cycles, then released
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ack_out", Ack_out, 0);
            chk("rst_send_out", Send_out, 0);
            chk("rst_data_out", Data_out, 0);
            chk("rst_count", count, 0);
            chk("rst_cp", cp, 0);
        end
        MR = 1'b0;
        #1;
        chk("rel_ack_out", Ack_out, 1);

        // 2: fill with A0..A3, no consumer
        Send_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Data_in = 8'hA0 + 8'(i);
            tick();
            chk("fill_cp", cp, 1);
            chk("fill_count", count, i + 1);
        end
        chk("full_ack_out", Ack_out, 0);
        chk("full_send_out", Send_out, 1);
        chk("full_head", Data_out, 8'hA0);

        // 3: full, pop and offered push in the same cycle: push refused
        Ack_in = 1'b1; Data_in = 8'hB0;
        #1;
        chk("nopass_ack_out", Ack_out, 0);
        chk("nopass_head", Data_out, 8'hA0);
        tick();
        chk("nopass_count", count, 3);
        chk("nopass_cp", cp, 0);
        chk("nopass_ack_next", Ack_out, 1);
        chk("drain_a1", Data_out, 8'hA1);
        tick();
        chk("b0_cp", cp, 1);
        chk("b0_count", count, 3);
        chk("drain_a2", Data_out, 8'hA2);
        Send_in = 1'b0;
        tick();
        chk("drain_a3", Data_out, 8'hA3);
        chk("drain_cnt2", count, 2);
        tick();
        chk("drain_b0", Data_out, 8'hB0);
        chk("drain_cnt1", count, 1);
        tick();
        chk("empty_count", count, 0);
        chk("empty_send_out", Send_out, 0);
        chk("empty_data_out", Data_out, 0);

        // 4: streaming through, 20 tokens, pointers wrap several times
        Send_in = 1'b1; Ack_in = 1'b1;
        #1;
        chk("stream_pre_send", Send_out, 0);
        for (int k = 0; k < 20; k++) begin
            Data_in = 8'h10 + 8'(k);
            tick();
            chk("stream_count", count, 1);
            chk("stream_send", Send_out, 1);
            chk("stream_data", Data_out, 8'h10 + 8'(k));
            chk("stream_cp", cp, 1);
        end

        // 5: reset mid-transfer with count=2
        Ack_in = 1'b0; Data_in = 8'h30;
        tick();
        chk("pre_mr_count", count, 2);
        MR = 1'b1; Send_in = 1'b1; Ack_in = 1'b1;
        #1;
        chk("mr_ack_out", Ack_out, 0);
        tick();
        chk("mr_count", count, 0);
        chk("mr_send_out", Send_out, 0);
        chk("mr_data_out", Data_out, 0);
        chk("mr_cp", cp, 0);
        MR = 1'b0; Send_in = 1'b0; Ack_in = 1'b0;
        #1;
        chk("mr_rel_ack", Ack_out, 1);

`ifdef CF_STAT_EN
        // 6: stall counter saturation at 15 with STAT_W=4
        chk("stall_rst", stall_cnt, 0);
        Send_in = 1'b1; Data_in = 8'h55;
        tick();
        Send_in = 1'b0;
        chk("stall_start", stall_cnt, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("stall_inc", stall_cnt, (i > 15) ? 15 : i);
        end
        chk("stall_head", Data_out, 8'h55);
        MR = 1'b1;
        tick();
        MR = 1'b0;
        chk("stall_clr", stall_cnt, 0);
        chk("stall_clr_count", count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
